sprite_motion_ctrl: RTL and testbench

Sequences the position of the 51x51 overlay sprite drawn by the VGA pipeline. Tracks which movement keys are held, using the PS/2 receiver's byte stream including make/break prefixes. Applies one clamped position step per video frame, so the sprite moves smoothly and stays on screen. Outputs feed the overlay address and bounds-test logic directly.

---
 rtl/strum_vga_pkg.sv | 62 ++++++
 rtl/sprite_motion_ctrl_if.sv | 15 +
 rtl/ps2_key_tracker.sv | 64 ++++++
 rtl/sprite_motion_ctrl.sv | 75 +++++++
 tb/tb_sprite_motion_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/strum_vga_pkg.sv
// Shared constants, scan codes, decoder state type and the clamped axis step
// used by the VGA sprite overlay control path.
package strum_vga_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int SPRITE_W_DEF = 51;
  localparam int STEP_DEF     = 4;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DN    = 8'h72;
  localparam logic [7:0] SC_LT    = 8'h6B;
  localparam logic [7:0] SC_RT    = 8'h74;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_e;

  // Flag bit order is {right,left,down,up}.
  function automatic logic [3:0] wasd_mask(input logic [7:0] b);
    case (b)
      SC_W:    return 4'b0001;
      SC_S:    return 4'b0010;
      SC_A:    return 4'b0100;
      SC_D:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    case (b)
      SC_UP:   return 4'b0001;
      SC_DN:   return 4'b0010;
      SC_LT:   return 4'b0100;
      SC_RT:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // One clamped step along an axis; opposing keys cancel out.
  function automatic logic [9:0] axis_step(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [10:0] step,
                                           input logic [10:0] pmax);
    logic [10:0] p;
    logic [9:0]  r;
    p = {1'b0, pos};
    r = pos;
    if (dec && !inc) begin
      if (p < step) r = '0;
      else          r = 10'(p - step);
    end else if (inc && !dec) begin
      if (p + step > pmax) r = 10'(pmax);
      else                 r = 10'(p + step);
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Keyboard byte stream in, frame timing in, sprite position and key state out.
interface sprite_motion_ctrl_if;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       frame_end;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [3:0] keys_held;
  logic       frame_pulse;

  modport master (output scan_valid, scan_data, frame_end,
                  input  sprite_x, sprite_y, keys_held, frame_pulse);
  modport slave  (input  scan_valid, scan_data, frame_end,
                  output sprite_x, sprite_y, keys_held, frame_pulse);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break decoder holding the four movement-key flags.
// Arrow keys (E0-prefixed) are decoded only when SPRITE_ARROW_KEYS_EN is defined.
module ps2_key_tracker
  import strum_vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_data,
  output logic [3:0] keys_held
);

  kbd_state_e state_q, state_d;
  logic [3:0] keys_q, keys_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_data == SC_BREAK)    state_d = BRK;
          else if (scan_data == SC_EXT) state_d = EXT;
          else                          keys_d  = keys_q | wasd_mask(scan_data);
        end
        BRK: begin
          keys_d  = keys_q & ~wasd_mask(scan_data);
          state_d = IDLE;
        end
`ifdef SPRITE_ARROW_KEYS_EN
        EXT: begin
          if (scan_data == SC_BREAK) state_d = EXT_BRK;
          else begin
            keys_d  = keys_q | arrow_mask(scan_data);
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          keys_d  = keys_q & ~arrow_mask(scan_data);
          state_d = IDLE;
        end
`else
        // Extended bytes (including a following F0) are swallowed.
        EXT:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign keys_held = keys_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-rate sprite position sequencer: one clamped step per frame_end rise,
// driven by held keys. Optional arrow-key decode via SPRITE_ARROW_KEYS_EN.
module sprite_motion_ctrl
  import strum_vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
)(
  input  logic                 clk,
  input  logic                 reset,
  sprite_motion_ctrl_if.slave  bus
);

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - SPRITE_W);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic [3:0] keys;
  logic       fe_cur_q, fe_prev_q, fe_prev_d;
  logic       seen_low_q, seen_low_d;
  logic       pulse_q, pulse_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       rise;

  ps2_key_tracker u_keys (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (bus.scan_valid),
    .scan_data  (bus.scan_data),
    .keys_held  (keys)
  );

  // fe_cur_q keeps sampling through reset so a level held high across reset
  // must fall before a rise is accepted.
  always_ff @(posedge clk) fe_cur_q <= bus.frame_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_prev_q  <= 1'b0;
      seen_low_q <= 1'b0;
      pulse_q    <= 1'b0;
      x_q        <= 10'(X_INIT);
      y_q        <= 10'(Y_INIT);
    end else begin
      fe_prev_q  <= fe_prev_d;
      seen_low_q <= seen_low_d;
      pulse_q    <= pulse_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    rise       = fe_cur_q && !fe_prev_q && seen_low_q;
    fe_prev_d  = fe_cur_q;
    seen_low_d = seen_low_q | ~fe_cur_q;
    pulse_d    = rise;
    x_d        = x_q;
    y_d        = y_q;
    if (rise) begin
      y_d = axis_step(y_q, keys[0], keys[1], STEP11, Y_MAX);
      x_d = axis_step(x_q, keys[2], keys[3], STEP11, X_MAX);
    end
  end

  assign bus.sprite_x    = x_q;
  assign bus.sprite_y    = y_q;
  assign bus.keys_held   = keys;
  assign bus.frame_pulse = pulse_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl; arrow-key checks follow SPRITE_ARROW_KEYS_EN.
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   nchk = 0;
  int   pulse_cnt = 0;
  int   base;

  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl #(.X_INIT(100), .Y_INIT(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_valid = 1'b1;
    bus.scan_data  = b;
    tick(1);
    bus.scan_valid = 1'b0;
    tick(1);
  endtask

  task automatic frame(input int hi);
    bus.frame_end = 1'b1;
    tick(hi);
    bus.frame_end = 1'b0;
    tick(3);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(3);
  endtask

  initial begin
    reset          = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_data  = '0;
    bus.frame_end  = 1'b1;
    tick(3);
    chk("rst_x", int'(bus.sprite_x), 100);
    chk("rst_y", int'(bus.sprite_y), 100);
    chk("rst_keys", int'(bus.keys_held), 0);
    chk("rst_pulse", int'(bus.frame_pulse), 0);
    reset = 1'b0;
    tick(4);
    chk("held_hi_no_pulse", pulse_cnt, 0);
    bus.frame_end = 1'b0;
    tick(2);

    send(8'h1D);
    chk("make_up", int'(bus.keys_held), 1);
    frames(3);
    chk("up3_y", int'(bus.sprite_y), 88);
    chk("up3_x", int'(bus.sprite_x), 100);
    chk("up3_pulses", pulse_cnt, 3);

    send(8'hF0); send(8'h1D);
    chk("brk_up", int'(bus.keys_held), 0);
    frames(2);
    chk("idle_y", int'(bus.sprite_y), 88);
    chk("idle_x", int'(bus.sprite_x), 100);

    send(8'h1D); send(8'h1B);
    chk("up_dn", int'(bus.keys_held), 3);
    frames(5);
    chk("cancel_y", int'(bus.sprite_y), 88);

    send(8'hF0); send(8'h1B);
    chk("brk_dn", int'(bus.keys_held), 1);
    base = pulse_cnt;
    frame(4);
    chk("long_hi_pulses", pulse_cnt - base, 1);
    chk("long_hi_y", int'(bus.sprite_y), 84);

    send(8'hF0); send(8'h1D); send(8'h1B);
    chk("dn_only", int'(bus.keys_held), 2);
    frames(86);
    chk("dn_428", int'(bus.sprite_y), 428);
    frame(3);
    chk("dn_clamp", int'(bus.sprite_y), 429);
    frame(3);
    chk("dn_stay", int'(bus.sprite_y), 429);

    send(8'hF0); send(8'h1B); send(8'h1D);
    frames(107);
    chk("up_1", int'(bus.sprite_y), 1);
    frame(3);
    chk("up_clamp", int'(bus.sprite_y), 0);
    frame(3);
    chk("up_stay", int'(bus.sprite_y), 0);

    send(8'hF0); send(8'h1D); send(8'h23);
    chk("rt_only", int'(bus.keys_held), 8);
    frames(122);
    chk("rt_588", int'(bus.sprite_x), 588);
    frame(3);
    chk("rt_clamp", int'(bus.sprite_x), 589);
    frame(3);
    chk("rt_stay", int'(bus.sprite_x), 589);

    send(8'h23);
    chk("typematic", int'(bus.keys_held), 8);
    send(8'hF0);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_x", int'(bus.sprite_x), 100);
    chk("mid_rst_y", int'(bus.sprite_y), 100);
    chk("mid_rst_keys", int'(bus.keys_held), 0);
    reset = 1'b0;
    tick(1);
    send(8'h1C);
    chk("post_rst_left", int'(bus.keys_held), 4);
    frame(3);
    chk("left_x", int'(bus.sprite_x), 96);
    chk("left_y", int'(bus.sprite_y), 100);

    send(8'hE0); send(8'h74);
`ifdef SPRITE_ARROW_KEYS_EN
    chk("arrow_rt_make", int'(bus.keys_held), 12);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("arrow_rt_brk", int'(bus.keys_held), 4);
    send(8'hE0); send(8'hF0); send(8'h1D);
    chk("ext_brk_nonarrow", int'(bus.keys_held), 4);
`else
    chk("ext_ignored", int'(bus.keys_held), 4);
    send(8'hE0); send(8'hF0); send(8'h1D);
    chk("ext_f0_then_make", int'(bus.keys_held), 5);
`endif

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
